// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ producers and the FIFO write arbiter.
// master: producers/FIFO side (req, req_data, full); slave: the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          full;
    logic [NUM_REQ-1:0]            gnt;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         data_in;
    logic [IW-1:0]                 owner;
    logic                          owner_valid;

    modport master (
        output req, req_data, full,
        input  gnt, w_en, data_in, owner, owner_valid
    );

    modport slave (
        input  req, req_data, full,
        output gnt, w_en, data_in, owner, owner_valid
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Ports: clk, rst_n (async, active-low), bus (fifo_wr_arbiter_if.slave):
//   req/req_data/full in; gnt/w_en/data_in/owner/owner_valid out.
// Optional burst locking is compiled in with FIFO_ARB_BURST_EN.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input logic               clk,
    input logic               rst_n,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || BURST_LEN < 1) begin : g_bad_cfg
        $error("fifo_wr_arbiter: unsupported parameters");
    end

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
        return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    logic [IW-1:0] ptr;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] start;
    logic [IW-1:0] win;
    logic          found;
    logic [IW-1:0] gi;
    logic          gv;

`ifdef FIFO_ARB_BURST_EN
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic {ARB, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ov_q;
    logic          keep;

    // Lock continues only while the owner still has a word pending.
    assign keep = (state == HOLD) && bus.req[owner_q];
`endif

    always_comb begin
        int idx;
        start = ptr;
        found = 1'b0;
        win   = '0;
        idx   = 0;
`ifdef FIFO_ARB_BURST_EN
        // Released lock: search resumes just past the old owner.
        if (state == HOLD) start = inc(owner_q);
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(start) + k) % NUM_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        gv = 1'b0;
        gi = win;
        if (rst_n && !bus.full) begin
`ifdef FIFO_ARB_BURST_EN
            if (keep) begin
                gv = 1'b1;
                gi = owner_q;
            end else begin
                gv = found;
            end
`else
            gv = found;
`endif
        end
    end

    assign bus.gnt     = gv ? (NUM_REQ'(1) << gi) : '0;
    assign bus.w_en    = gv;
    assign bus.data_in = gv ? bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH]
                            : '0;
    assign bus.owner   = owner_q;

`ifdef FIFO_ARB_BURST_EN
    assign bus.owner_valid = ov_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            owner_q <= '0;
            state   <= ARB;
            cnt     <= '0;
            ov_q    <= 1'b0;
        end else if (!bus.full) begin
            if (keep) begin
                if (cnt == CW'(BURST_LEN - 1)) begin
                    state <= ARB;
                    ptr   <= inc(owner_q);
                    cnt   <= '0;
                    ov_q  <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                if (state == HOLD) begin
                    state <= ARB;
                    ptr   <= inc(owner_q);
                    cnt   <= '0;
                    ov_q  <= 1'b0;
                end
                // A fresh winner overrides the release defaults above.
                if (found) begin
                    owner_q <= win;
                    ptr     <= inc(win);
                    if (BURST_LEN > 1) begin
                        state <= HOLD;
                        cnt   <= CW'(1);
                        ov_q  <= 1'b1;
                    end
                end
            end
        end
    end
`else
    assign bus.owner_valid = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            owner_q <= '0;
        end else if (!bus.full && found) begin
            owner_q <= win;
            ptr     <= inc(win);
        end
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: randomized producers against a
// last-winner/lock reference model, checked every cycle.
module tb_fifo_wr_arbiter;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int BL = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus ();

    fifo_wr_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ(N),
        .BURST_LEN(BL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [N-1:0] pend = '0;
    logic [DW-1:0] dat [N];

    // Reference model: last winner, optional lock owner and beat count.
    int   last = -1;
    bit   locked = 1'b0;
    int   lown = 0;
    int   beats = 0;
    int   exp_owner = 0;

    function automatic int pick(input logic [N-1:0] r, input int s);
        for (int k = 0; k < N; k++) begin
            if (r[(s + k) % N]) return (s + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        last      = -1;
        locked    = 1'b0;
        lown      = 0;
        beats     = 0;
        exp_owner = 0;
    endtask

    task automatic take(input int g);
        last = g;
        if (BURST && BL > 1) begin
            locked = 1'b1;
            lown   = g;
            beats  = 1;
        end
    endtask

    task automatic cycle(input logic [N-1:0] mask, input bit fl,
                         input int rate);
        int g;
        logic [N-1:0] eg;
        logic [DW-1:0] ed;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && mask[i] && ($urandom % 100) < rate) begin
                pend[i] = 1'b1;
                dat[i]  = DW'($urandom);
            end
            bus.req_data[i*DW +: DW] = pend[i] ? dat[i] : DW'($urandom);
        end
        bus.req  = pend;
        bus.full = fl;
        @(negedge clk);
        if (!rst_n) model_reset();
        if (!rst_n || fl) g = -1;
        else if (locked && pend[lown]) g = lown;
        else g = pick(pend, locked ? (lown + 1) % N : (last + 1) % N);
        eg = (g >= 0) ? (N'(1) << g) : '0;
        ed = (g >= 0) ? dat[g] : '0;
        vectors++;
        assert (bus.gnt === eg) else begin
            miscompares++;
            $error("FAIL gnt: got %b want %b", bus.gnt, eg);
        end
        assert (bus.w_en === (g >= 0)) else begin
            miscompares++;
            $error("FAIL w_en: got %b want %b", bus.w_en, g >= 0);
        end
        assert (bus.data_in === ed) else begin
            miscompares++;
            $error("FAIL data_in: got %h want %h", bus.data_in, ed);
        end
        assert (int'(bus.owner) == exp_owner) else begin
            miscompares++;
            $error("FAIL owner: got %0d want %0d", bus.owner, exp_owner);
        end
        assert (bus.owner_valid === locked) else begin
            miscompares++;
            $error("FAIL owner_valid: got %b want %b",
                   bus.owner_valid, locked);
        end
        @(posedge clk);
        if (rst_n) begin
            if (g >= 0) begin
                pend[g]   = 1'b0;
                exp_owner = g;
            end
            if (locked && !fl) begin
                if (g == lown) begin
                    beats++;
                    if (beats == BL) begin
                        locked = 1'b0;
                        last   = lown;
                    end
                end else begin
                    locked = 1'b0;
                    last   = lown;
                    if (g >= 0) take(g);
                end
            end else if (!locked && g >= 0) begin
                take(g);
            end
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * N * BL && pend != '0; i++) cycle('0, 1'b0, 0);
        vectors++;
        assert (pend == '0) else begin
            miscompares++;
            $error("FAIL drain: pending %b want 0000", pend);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        cycle('0, 1'b0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) dat[i] = '0;
        bus.req      = '0;
        bus.req_data = '0;
        bus.full     = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) cycle('1, 1'b0, 100);
        rst_n = 1'b1;
        repeat (8) cycle('1, 1'b0, 100);
        drain();
        repeat (8) cycle(4'b0101, 1'b0, 100);
        repeat (3) cycle('1, 1'b1, 100);
        repeat (6) cycle('1, 1'b0, 100);
        rst_n = 1'b0;
        cycle('1, 1'b0, 100);
        rst_n = 1'b1;
        repeat (6) cycle('1, 1'b0, 100);
        repeat (300) cycle(N'($urandom), ($urandom % 4) == 0, 60);
        drain();
`ifdef FIFO_ARB_BURST_EN
        pulse_reset();
        repeat (12) cycle(4'b0011, 1'b0, 100);
        drain();
        pulse_reset();
        repeat (2) cycle(4'b0011, 1'b0, 100);
        repeat (3) cycle(4'b0011, 1'b1, 100);
        repeat (6) cycle(4'b0011, 1'b0, 100);
        drain();
        pulse_reset();
        cycle(4'b0001, 1'b0, 100);
        repeat (3) cycle(4'b0100, 1'b0, 100);
        drain();
        pulse_reset();
        repeat (2) cycle(4'b0011, 1'b0, 100);
        rst_n = 1'b0;
        cycle(4'b0011, 1'b0, 100);
        rst_n = 1'b1;
        repeat (4) cycle(4'b0011, 1'b0, 100);
        repeat (200) cycle(N'($urandom), ($urandom % 4) == 0, 60);
`endif
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `synchronous_fifo` write port among `NUM_REQ` producers. It sits directly in front of the FIFO: it drives `w_en`/`data_in` and observes `full`. It returns a per-requester accept strobe so each producer knows exactly when its word was written. The read side of the FIFO is untouched.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO.
- `NUM_REQ`, 4, number of requesters (2..16).
- `BURST_LEN`, 4, maximum consecutive beats per grant when bursting is compiled in (≥1).
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  requester i has a valid word; held until accepted.
- `req_data`  in  NUM_REQ*DATA_WIDTH  word of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `full`  in  1  FIFO full flag.
- `gnt`  out  NUM_REQ  one-hot accept strobe; gnt[i]=1 means the word is written at this posedge.
- `w_en`  out  1  FIFO write enable, equal to |gnt.
- `data_in`  out  DATA_WIDTH  req_data slice of the granted requester; 0 when no grant.
- `owner`  out  $clog2(NUM_REQ)  index of the current/last winner.
- `owner_valid`  out  1  high while a burst lock is held.

## Operation
- Registered state: `ptr` (round-robin start index), `state` ∈ {ARB, HOLD}, `owner`, burst count `cnt` ($clog2(BURST_LEN+1) bits).
- Grants are combinational from `req`, `full`, and the registered state. `gnt` is all-zero whenever `full`=1 or `rst_n`=0.
- ARB: search `req` starting at `ptr`, incrementing mod NUM_REQ. The first set bit wins.
  - The winner gets `gnt` and `owner` takes its index.
  - `ptr` ← winner+1 mod NUM_REQ.
  - No request pending: no grant, state unchanged.
- HOLD (burst build only):
  - If `req[owner]`=1 and `full`=0: grant `owner` and increment `cnt`. When `cnt` reaches BURST_LEN, return to ARB with `ptr` ← owner+1.
  - If `full`=1: no grant; `cnt` and `owner` are held; stay in HOLD.
  - If `req[owner]`=0: release the lock and arbitrate the same cycle exactly as in ARB, with the search starting at owner+1. This adds no bubble cycle.
- Non-granted requesters must hold `req` and data stable. The arbiter never drops a word and never writes while `full`=1.
- Reset, async, every state element: `ptr`=0, `state`=ARB, `owner`=0, `cnt`=0, `owner_valid`=0.
  - Outputs during reset: `gnt`=0, `w_en`=0, `data_in`=0.
  - Reset asserted mid-burst discards the lock. The interrupted requester re-competes from `ptr`=0.

## Timing
- Zero-cycle latency: req→gnt/w_en/data_in is combinational in the same cycle, and the FIFO captures at the next posedge.
- Throughput is one word per cycle while `full`=0.
- `full` deasserting lets a grant issue in that same cycle.
- Fairness without bursts: any requester held high is granted within NUM_REQ cycles of `full`=0.
- Fairness with bursts: the bound is NUM_REQ*BURST_LEN cycles.
- `ptr` wraps from NUM_REQ-1 to 0.
- `owner_valid` is registered and asserts the cycle after the first beat of a burst.

## Configuration
- `FIFO_ARB_BURST_EN` defined:
  - ARB→HOLD on a grant, with `cnt`=1 and `owner_valid`=1.
  - The winner keeps the port for up to BURST_LEN consecutive accepted beats.
  - When BURST_LEN=1, HOLD is never entered.
- Undefined:
  - HOLD and `cnt` are not synthesized, and `owner_valid` is tied to 0.
  - Every grant advances `ptr`, giving strict per-beat round-robin.
  - BURST_LEN is ignored.

## Test plan
- Reset with req=4'b1111, rst_n=0 → gnt=0, w_en=0, data_in=0. After release: grants 0,1,2,3,0… (burst macro off), data_in matching each slice; the FIFO read-back order is identical.
- Reset mid-burst (macro on, burst at cnt=2) → gnt=0 immediately; after release arbitration restarts from requester 0.
- req=4'b0101, full=0 (macro off) → gnt alternates 0001/0100 every cycle, and requesters 1 and 3 are never granted.
- Macro on, BURST_LEN=4, req=4'b0011 held → gnt[0] for 4 cycles, then gnt[1] for 4 cycles, with `owner_valid` high during each burst.
- Macro on: `full`=1 for 3 cycles at cnt=2 → no w_en during those cycles; after full drops, exactly 2 more beats for the same owner.
- Macro on: owner drops req at cnt=1 while req[2]=1 → gnt[2] in the same cycle, with no idle cycle.
